// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: N-channel W-bit registered mux with manual/auto-scan select and valid/ready output
//   clk, rst (async, active-high) | en load enable | mode 0=manual sel, 1=auto-scan
//   sel manual channel | x packed inputs, channel i = x[i*W +: W] | out_rdy downstream ready
//   m registered data | m_vld m holds unconsumed data | ch channel m came from
//   ch_mask channel enable mask, present only when CH_MASK_EN is defined
module mux_scan_nx1 #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  x,
  input  logic            out_rdy,
  output logic [W-1:0]    m,
  output logic            m_vld,
  output logic [SELW-1:0] ch
`ifdef CH_MASK_EN
  ,
  input  logic [N-1:0]    ch_mask
`endif
);
  localparam int P = 1 << SELW;
  localparam int DWW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [DWW-1:0] DLAST = DWW'(DWELL - 1);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, state_nx;
  logic [SELW-1:0] scan_ptr, scan_nx, ptr, nxt;
  logic [DWW-1:0] dwell, dwell_nx, cnt;
  logic [N-1:0] mask_eff;
  logic [P-1:0] mask_pad;
  logic [W-1:0] pick;
  logic mode_q, hold, load, found;
`ifdef CH_MASK_EN
  assign mask_eff = ch_mask;
`else
  assign mask_eff = '1;
`endif
  // padding to 2**SELW makes out-of-range selects read as disabled channels
  assign mask_pad = P'(mask_eff);
  assign ptr = mode ? scan_ptr : sel;
  assign m_vld = state != IDLE;
  assign hold = m_vld && !out_rdy;
  assign load = en && mask_pad[ptr] && !hold;
  assign cnt = mode != mode_q ? '0 : dwell;
  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++)
      if (ptr == SELW'(i)) pick = x[i*W +: W];
  end
  always_comb begin
    nxt = scan_ptr;
    found = 1'b0;
    for (int k = 1; k <= N; k++)
      if (!found && mask_pad[(int'(scan_ptr) + k) % N]) begin
        nxt = SELW'((int'(scan_ptr) + k) % N);
        found = 1'b1;
      end
  end
  always_comb begin
    scan_nx = scan_ptr;
    dwell_nx = cnt;
    if (mode && !hold) begin
      if (!mask_pad[scan_ptr]) begin
        scan_nx = nxt;
        dwell_nx = '0;
      end else if (load) begin
        scan_nx = cnt == DLAST ? nxt : scan_ptr;
        dwell_nx = cnt == DLAST ? '0 : cnt + 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    if (load) state_nx = LOAD;
    else if (m_vld) state_nx = out_rdy ? IDLE : HOLD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m <= '0;
      ch <= '0;
      scan_ptr <= '0;
      dwell <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nx;
      mode_q <= mode;
      scan_ptr <= scan_nx;
      dwell <= dwell_nx;
      if (load) begin
        m <= pick;
        ch <= ptr;
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: directed checks of mux_scan_nx1 (N=4/DWELL=2 and N=5/DWELL=1 instances)
module tb_mux_scan_nx1;
  logic clk = 1'b0, rst = 1'b1;
  logic en_a = 1'b0, mode_a = 1'b0, out_rdy_a = 1'b1;
  logic [1:0] sel_a = '0;
  logic [31:0] x_a = 32'h44332211;
  logic [7:0] m_a;
  logic m_vld_a;
  logic [1:0] ch_a;
  logic en_b = 1'b0, mode_b = 1'b0, out_rdy_b = 1'b1;
  logic [2:0] sel_b = '0;
  logic [39:0] x_b = 40'h5544332211;
  logic [7:0] m_b;
  logic m_vld_b;
  logic [2:0] ch_b;
`ifdef CH_MASK_EN
  logic [3:0] ch_mask_a = 4'b1111;
  logic [4:0] ch_mask_b = 5'b11111;
`endif
  int n_run = 0, n_fail = 0;
  int seq_a[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int seq_tail[6] = '{1, 2, 2, 3, 3, 0};
  int seq_b[6] = '{0, 1, 2, 3, 4, 0};
  always #5 clk = ~clk;
  mux_scan_nx1 #(.N(4), .W(8), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a), .x(x_a),
    .out_rdy(out_rdy_a), .m(m_a), .m_vld(m_vld_a), .ch(ch_a)
`ifdef CH_MASK_EN
    , .ch_mask(ch_mask_a)
`endif
  );
  mux_scan_nx1 #(.N(5), .W(8), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b), .x(x_b),
    .out_rdy(out_rdy_b), .m(m_b), .m_vld(m_vld_b), .ch(ch_b)
`ifdef CH_MASK_EN
    , .ch_mask(ch_mask_b)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_vld", {31'b0, m_vld_a}, 0);
    chk("rst_m", {24'b0, m_a}, 0);
    rst = 1'b0;
    sel_a = 2'd2; en_a = 1'b1; out_rdy_a = 1'b1;
    step();
    chk("man_m", {24'b0, m_a}, 32'h33);
    chk("man_ch", {30'b0, ch_a}, 2);
    chk("man_vld", {31'b0, m_vld_a}, 1);
    out_rdy_a = 1'b0; sel_a = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_m%0d", i), {24'b0, m_a}, 32'h33);
      chk($sformatf("bp_vld%0d", i), {31'b0, m_vld_a}, 1);
    end
    chk("bp_ch", {30'b0, ch_a}, 2);
    out_rdy_a = 1'b1;
    step();
    chk("bp_rel_m", {24'b0, m_a}, 32'h22);
    chk("bp_rel_ch", {30'b0, ch_a}, 1);
    en_a = 1'b0;
    step();
    chk("drain_vld", {31'b0, m_vld_a}, 0);
    chk("drain_m", {24'b0, m_a}, 32'h22);
    en_a = 1'b1; sel_a = 2'd0;
    step();
    chk("pre_rst_vld", {31'b0, m_vld_a}, 1);
    chk("pre_rst_m", {24'b0, m_a}, 32'h11);
    en_a = 1'b0; sel_a = 2'd3;
    step();
    en_a = 1'b1;
    step();
    chk("pre_rst_ch", {30'b0, ch_a}, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_m", {24'b0, m_a}, 0);
    chk("async_vld", {31'b0, m_vld_a}, 0);
    chk("async_ch", {30'b0, ch_a}, 0);
    @(negedge clk);
    rst = 1'b0; mode_a = 1'b1; en_a = 1'b1; out_rdy_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("scan%0d", i), {30'b0, ch_a}, seq_a[i]);
      if (i == 2) begin
        out_rdy_a = 1'b0;
        for (int s = 0; s < 2; s++) begin
          step();
          chk($sformatf("scan_stall%0d", s), {30'b0, ch_a}, 1);
        end
        out_rdy_a = 1'b1;
        for (int t = 0; t < 6; t++) begin
          step();
          chk($sformatf("scan_resume%0d", t), {30'b0, ch_a}, seq_tail[t]);
        end
        break;
      end
    end
    mode_a = 1'b0; sel_a = 2'd3;
    step();
    chk("mchg_man", {30'b0, ch_a}, 3);
    mode_a = 1'b1;
    step();
    chk("mchg_scan0", {30'b0, ch_a}, 0);
    step();
    chk("mchg_scan1", {30'b0, ch_a}, 0);
    step();
    chk("mchg_scan2", {30'b0, ch_a}, 1);
    en_a = 1'b0;
    en_b = 1'b1; mode_b = 1'b0; sel_b = 3'd5; out_rdy_b = 1'b1;
    step();
    chk("b_illegal_vld", {31'b0, m_vld_b}, 0);
    sel_b = 3'd4;
    step();
    chk("b_sel4_vld", {31'b0, m_vld_b}, 1);
    chk("b_sel4_m", {24'b0, m_b}, 32'h55);
    chk("b_sel4_ch", {29'b0, ch_b}, 4);
    sel_b = 3'd5;
    step();
    chk("b_drain_vld", {31'b0, m_vld_b}, 0);
    chk("b_drain_m", {24'b0, m_b}, 32'h55);
    mode_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("b_scan%0d", i), {29'b0, ch_b}, seq_b[i]);
    end
`ifdef CH_MASK_EN
    begin
      int exp_m[5] = '{1, 1, 3, 3, 1};
      int got_n = 0;
      en_b = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ch_mask_a = 4'b1010; mode_a = 1'b1; en_a = 1'b1; out_rdy_a = 1'b1;
      for (int t = 0; t < 16 && got_n < 5; t++) begin
        step();
        if (m_vld_a) begin
          chk($sformatf("mask%0d", got_n), {30'b0, ch_a}, exp_m[got_n]);
          got_n++;
        end
      end
      chk("mask_count", got_n, 5);
      ch_mask_a = 4'b0000;
      step();
      step();
      chk("mask0_vld", {31'b0, m_vld_a}, 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
